iexu_issue_buffer: RTL and testbench
====================================

Name: iexu_issue_buffer

Overview:
Small operand/operation queue directly upstream of the integer execution unit. It accepts decoded ALU operations (an iexu_conf plus two XLEN operands and a destination tag) from the decode stage over a valid/ready handshake. It presents the oldest entry to the IEXU, whose decoder consumes out_conf. It decouples decode from execute stalls and supports a pipeline flush.

Parameters:
XLEN, 32, operand/result data width
DEPTH, 2, number of queue entries; power of two, >= 2
TAGW, 5, register tag width (rd/rs)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous flush; discards all entries
in_valid  input  1  decode presents an operation
in_ready  output  1  buffer can accept this cycle
in_conf  input  iexu_conf  operation (add/sub/and/or/xor/sll/srl/sra)
in_op_a  input  XLEN  operand A
in_op_b  input  XLEN  operand B
in_rd  input  TAGW  destination tag
out_valid  output  1  head entry is issuable
out_ready  input  1  IEXU accepts head this cycle
out_conf  output  iexu_conf  head operation
out_op_a  output  XLEN  head operand A
out_op_b  output  XLEN  head operand B
out_rd  output  TAGW  head destination tag
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Circular buffer: write pointer, read pointer, occupancy counter. Pointers wrap modulo DEPTH.
- push = in_valid & in_ready & !flush. pop = out_valid & out_ready & !flush.
- in_ready = (count != DEPTH). It is combinational from registered count only and never depends on out_ready. When full, no push occurs even if a pop happens in the same cycle.
- out_valid = (count != 0), subject to the optional-feature gating below. out_* are driven combinationally from the head entry.
- Latency: an entry pushed in cycle N appears on out_* in cycle N+1 at the earliest. There is no combinational in->out path.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Push into empty with out_ready=1 in the same cycle: push only. The entry is popped no earlier than N+1.
- out_* hold stable while out_valid=1 and out_ready=0.
- flush: count, read pointer and write pointer go to 0 at the next edge. in_valid and out_ready are ignored in that cycle, and flush takes priority over everything else. Entry payloads need not be cleared.
- Reset (async, may occur mid-operation): count=0, pointers=0, all entry payloads cleared.
  - out_valid=0, out_conf=add_conf, out_op_a=0, out_op_b=0, out_rd=0.
  - in_ready=1 while rst is high and after it deasserts.
- Occupancy counter is DEPTH-saturating by construction; overflow and underflow cannot occur.

Optional Feature:
Macro IEXU_FWD_EN enables writeback capture into queued operands.
With the macro defined, the block adds these ports:
- in_rs1, in_rs2 (TAGW): source tags
- in_pend_a, in_pend_b (1): operand not yet available
- wb_valid (1), wb_tag (TAGW), wb_data (XLEN): writeback bus

Each entry stores both tags and both pending bits. Capture rules:
- Each cycle with wb_valid=1 and wb_tag!=0, every valid entry whose pending operand tag matches wb_tag captures wb_data into that operand and clears its pending bit.
- An entry being pushed in the same cycle also captures, so it is stored with pending=0.
- Tag 0 is never treated as pending: pending is forced to 0 at push.
- out_valid = (count!=0) & !head.pend_a & !head.pend_b.
- Pending bits reset and flush to 0.

Without the macro: the extra ports are absent, operands are stored as given, and out_valid = (count!=0).

Test Plan:
- Reset/idle: assert rst mid-stream with count=2 -> next cycle count=0, out_valid=0, out_conf=add_conf, in_ready=1.
- Fill/backpressure: push sub(5,3,rd=1) then xor(0xF0,0x0F,rd=2) with out_ready=0 -> count=2, in_ready=0. A third in_valid is dropped. Head shows sub,5,3,rd=1, held stable.
- Drain order with wrap: continuous push and pop of 6 ops (add, sll, srl, sra, and, or) with out_ready=1 -> outputs appear in order, each one cycle after its push, and count stays at 1 in steady state.
- Simultaneous push/pop at count=1 -> count stays 1, out_* advance to the newer entry next cycle.
- Flush with count=2 plus concurrent in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, and the concurrent push is not stored.
- IEXU_FWD_EN: push add with in_pend_a=1, in_rs1=7; two cycles later wb_valid=1, wb_tag=7, wb_data=0x1234 -> out_valid rises the next cycle with out_op_a=0x1234. A same-cycle push with a matching wb is stored with pending=0.

Source files
------------

// File: rtl/iexu_issue_buffer.sv
// Issue queue between decode and the IEXU: DEPTH-entry circular buffer of ALU operations.
// Latency: an entry pushed in cycle N is visible on out_* in cycle N+1; there is no in->out comb path.
// Backpressure: in_ready = not full, taken from registered count only; a full buffer refuses push even on a same-cycle pop.
//
// Ports:
//   clk, rst (async, active-high), flush (sync, discards all entries)
//   in_valid/in_ready, in_conf, in_op_a, in_op_b, in_rd   : decode-side enqueue
//   out_valid/out_ready, out_conf, out_op_a, out_op_b, out_rd : head entry towards the IEXU
//   count : current occupancy
// Optional build macro IEXU_FWD_EN adds in_rs1/in_rs2, in_pend_a/in_pend_b and the
// writeback bus wb_valid/wb_tag/wb_data; queued operands then capture matching writebacks
// and the head only issues once both operands are available.

package iexu_pkg;
    typedef enum logic [2:0] {
        add_conf = 3'd0,
        sub_conf = 3'd1,
        and_conf = 3'd2,
        or_conf  = 3'd3,
        xor_conf = 3'd4,
        sll_conf = 3'd5,
        srl_conf = 3'd6,
        sra_conf = 3'd7
    } iexu_conf;
endpackage

module iexu_issue_buffer
    import iexu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAGW  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  iexu_conf               in_conf,
    input  logic [XLEN-1:0]        in_op_a,
    input  logic [XLEN-1:0]        in_op_b,
    input  logic [TAGW-1:0]        in_rd,
`ifdef IEXU_FWD_EN
    input  logic [TAGW-1:0]        in_rs1,
    input  logic [TAGW-1:0]        in_rs2,
    input  logic                   in_pend_a,
    input  logic                   in_pend_b,
    input  logic                   wb_valid,
    input  logic [TAGW-1:0]        wb_tag,
    input  logic [XLEN-1:0]        wb_data,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output iexu_conf               out_conf,
    output logic [XLEN-1:0]        out_op_a,
    output logic [XLEN-1:0]        out_op_b,
    output logic [TAGW-1:0]        out_rd,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;

    typedef struct packed {
        iexu_conf        conf;
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [TAGW-1:0] rd;
`ifdef IEXU_FWD_EN
        logic [TAGW-1:0] rs1;
        logic [TAGW-1:0] rs2;
        logic            pend_a;
        logic            pend_b;
`endif
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            push_entry;
    logic [PTRW-1:0]   wr_ptr;
    logic [PTRW-1:0]   rd_ptr;
    logic              push;
    logic              pop;

    assign in_ready = (count != CW'(DEPTH));

    assign out_conf = mem[rd_ptr].conf;
    assign out_op_a = mem[rd_ptr].op_a;
    assign out_op_b = mem[rd_ptr].op_b;
    assign out_rd   = mem[rd_ptr].rd;

`ifdef IEXU_FWD_EN
    logic             wb_hit;
    logic [DEPTH-1:0] ent_vld;

    // Tag 0 is the hardwired zero register and never carries a real writeback.
    assign wb_hit = wb_valid && (wb_tag != '0);

    // A slot holds a live entry when its distance from the head is below the occupancy.
    always_comb begin
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_vld[i] = ({1'b0, PTRW'(PTRW'(i) - rd_ptr)} < count);
        end
    end

    assign out_valid = (count != '0) && !mem[rd_ptr].pend_a && !mem[rd_ptr].pend_b;
`else
    assign out_valid = (count != '0);
`endif

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Incoming entry; with forwarding it also snoops the writeback of the same cycle so it
    // is never stored waiting on a value that already went by.
    always_comb begin
        push_entry      = '0;
        push_entry.conf = in_conf;
        push_entry.op_a = in_op_a;
        push_entry.op_b = in_op_b;
        push_entry.rd   = in_rd;
`ifdef IEXU_FWD_EN
        push_entry.rs1    = in_rs1;
        push_entry.rs2    = in_rs2;
        push_entry.pend_a = in_pend_a && (in_rs1 != '0);
        push_entry.pend_b = in_pend_b && (in_rs2 != '0);
        if (wb_hit && push_entry.pend_a && (in_rs1 == wb_tag)) begin
            push_entry.op_a   = wb_data;
            push_entry.pend_a = 1'b0;
        end
        if (wb_hit && push_entry.pend_b && (in_rs2 == wb_tag)) begin
            push_entry.op_b   = wb_data;
            push_entry.pend_b = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wr_ptr == PTRW'(i))) begin
                    mem[i] <= push_entry;
                end
`ifdef IEXU_FWD_EN
                else if (flush) begin
                    mem[i].pend_a <= 1'b0;
                    mem[i].pend_b <= 1'b0;
                end else if (ent_vld[i] && wb_hit) begin
                    if (mem[i].pend_a && (mem[i].rs1 == wb_tag)) begin
                        mem[i].op_a   <= wb_data;
                        mem[i].pend_a <= 1'b0;
                    end
                    if (mem[i].pend_b && (mem[i].rs2 == wb_tag)) begin
                        mem[i].op_b   <= wb_data;
                        mem[i].pend_b <= 1'b0;
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_iexu_issue_buffer.sv
// Self-checking bench for iexu_issue_buffer: directed scenarios plus a randomized run
// compared against a queue-based reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_iexu_issue_buffer;
    import iexu_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int TAGW  = 5;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    iexu_conf        in_conf;
    logic [XLEN-1:0] in_op_a;
    logic [XLEN-1:0] in_op_b;
    logic [TAGW-1:0] in_rd;
    logic            out_valid;
    logic            out_ready;
    iexu_conf        out_conf;
    logic [XLEN-1:0] out_op_a;
    logic [XLEN-1:0] out_op_b;
    logic [TAGW-1:0] out_rd;
    logic [CW-1:0]   count;
`ifdef IEXU_FWD_EN
    logic [TAGW-1:0] in_rs1    = '0;
    logic [TAGW-1:0] in_rs2    = '0;
    logic            in_pend_a = 1'b0;
    logic            in_pend_b = 1'b0;
    logic            wb_valid  = 1'b0;
    logic [TAGW-1:0] wb_tag    = '0;
    logic [XLEN-1:0] wb_data   = '0;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        iexu_conf        conf;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [TAGW-1:0] rd;
    } ment_t;

    always #5 clk = ~clk;

    iexu_issue_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_conf   (in_conf),
        .in_op_a   (in_op_a),
        .in_op_b   (in_op_b),
        .in_rd     (in_rd),
`ifdef IEXU_FWD_EN
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_pend_a (in_pend_a),
        .in_pend_b (in_pend_b),
        .wb_valid  (wb_valid),
        .wb_tag    (wb_tag),
        .wb_data   (wb_data),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_conf  (out_conf),
        .out_op_a  (out_op_a),
        .out_op_b  (out_op_b),
        .out_rd    (out_rd),
        .count     (count)
    );

    // Apply one cycle of inputs and return at the following falling edge.
    task automatic drive(input logic v, input iexu_conf c, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAGW-1:0] rd,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_conf   = c;
        in_op_a   = a;
        in_op_b   = b;
        in_rd     = rd;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || count !== CW'(0)) begin
            errors++;
            $display("FAIL reset_held in_ready=%b count=%0d want 1/0", in_ready, count);
        end
        rst = 1'b0;
        drive(1'b1, sub_conf, 32'd11, 32'd22, 5'd3, 1'b0, 1'b0);
        drive(1'b1, or_conf, 32'd33, 32'd44, 5'd4, 1'b0, 1'b0);
        checks++;
        if (count !== CW'(2)) begin
            errors++;
            $display("FAIL pre_reset_count got %0d want 2", count);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (count !== CW'(0) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset count=%0d out_valid=%b in_ready=%b want 0/0/1",
                     count, out_valid, in_ready);
        end
        checks++;
        if (out_conf !== add_conf || out_op_a !== '0 || out_op_b !== '0 || out_rd !== '0) begin
            errors++;
            $display("FAIL reset_payload conf=%0d a=%0h b=%0h rd=%0d want add/0/0/0",
                     out_conf, out_op_a, out_op_b, out_rd);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, add_conf, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (count !== CW'(0) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle count=%0d out_valid=%b in_ready=%b want 0/0/1",
                     count, out_valid, in_ready);
        end
    endtask

    task automatic test_fill();
        drive(1'b1, sub_conf, 32'd5, 32'd3, 5'd1, 1'b0, 1'b0);
        checks++;
        if (count !== CW'(1) || out_valid !== 1'b1 || out_conf !== sub_conf) begin
            errors++;
            $display("FAIL fill_first count=%0d valid=%b conf=%0d want 1/1/sub", count, out_valid, out_conf);
        end
        drive(1'b1, xor_conf, 32'hF0, 32'h0F, 5'd2, 1'b0, 1'b0);
        checks++;
        if (count !== CW'(2) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full count=%0d in_ready=%b want 2/0", count, in_ready);
        end
        // Third offer while full must be dropped; head must hold.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, and_conf, 32'hDEAD, 32'hBEEF, 5'd9, 1'b0, 1'b0);
            checks++;
            if (count !== CW'(2) || out_valid !== 1'b1 || out_conf !== sub_conf ||
                out_op_a !== 32'd5 || out_op_b !== 32'd3 || out_rd !== 5'd1) begin
                errors++;
                $display("FAIL fill_hold count=%0d conf=%0d a=%0h b=%0h rd=%0d want 2/sub/5/3/1",
                         count, out_conf, out_op_a, out_op_b, out_rd);
            end
        end
        // Full with a pop offered: still no push this cycle.
        drive(1'b1, and_conf, 32'hDEAD, 32'hBEEF, 5'd9, 1'b1, 1'b0);
        checks++;
        if (count !== CW'(1) || out_conf !== xor_conf || out_op_a !== 32'hF0 ||
            out_op_b !== 32'h0F || out_rd !== 5'd2) begin
            errors++;
            $display("FAIL full_pop count=%0d conf=%0d a=%0h rd=%0d want 1/xor/f0/2",
                     count, out_conf, out_op_a, out_rd);
        end
        drive(1'b0, add_conf, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (count !== CW'(0) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_drain count=%0d valid=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_drain_wrap();
        iexu_conf ops [6];
        ops[0] = add_conf; ops[1] = sll_conf; ops[2] = srl_conf;
        ops[3] = sra_conf; ops[4] = and_conf; ops[5] = or_conf;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, ops[k], 32'(k * 16 + 1), 32'(k + 2), 5'(k + 3), 1'b1, 1'b0);
            checks++;
            if (count !== CW'(1) || out_valid !== 1'b1 || out_conf !== ops[k] ||
                out_op_a !== 32'(k * 16 + 1) || out_op_b !== 32'(k + 2) || out_rd !== 5'(k + 3)) begin
                errors++;
                $display("FAIL wrap_%0d count=%0d conf=%0d a=%0h b=%0h rd=%0d want 1/%0d/%0h/%0h/%0d",
                         k, count, out_conf, out_op_a, out_op_b, out_rd,
                         ops[k], k * 16 + 1, k + 2, k + 3);
            end
        end
        drive(1'b0, add_conf, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (count !== CW'(0) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drain count=%0d valid=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, sub_conf, 32'h100, 32'h200, 5'd7, 1'b0, 1'b0);
        drive(1'b1, xor_conf, 32'h300, 32'h400, 5'd8, 1'b1, 1'b0);
        checks++;
        if (count !== CW'(1) || out_conf !== xor_conf || out_op_a !== 32'h300 ||
            out_op_b !== 32'h400 || out_rd !== 5'd8) begin
            errors++;
            $display("FAIL simul count=%0d conf=%0d a=%0h rd=%0d want 1/xor/300/8",
                     count, out_conf, out_op_a, out_rd);
        end
        drive(1'b0, add_conf, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        drive(1'b1, and_conf, 32'h1, 32'h2, 5'd1, 1'b0, 1'b0);
        drive(1'b1, or_conf, 32'h3, 32'h4, 5'd2, 1'b0, 1'b0);
        drive(1'b1, sll_conf, 32'h5, 32'h6, 5'd3, 1'b1, 1'b1);
        checks++;
        if (count !== CW'(0) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush count=%0d valid=%b in_ready=%b want 0/0/1", count, out_valid, in_ready);
        end
        drive(1'b0, add_conf, '0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (count !== CW'(0) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_nostore count=%0d valid=%b want 0/0", count, out_valid);
        end
        // Pointers restart at slot 0: a fresh push must appear correctly.
        drive(1'b1, srl_conf, 32'h77, 32'h88, 5'd5, 1'b0, 1'b0);
        checks++;
        if (count !== CW'(1) || out_conf !== srl_conf || out_op_a !== 32'h77) begin
            errors++;
            $display("FAIL flush_restart count=%0d conf=%0d a=%0h want 1/srl/77", count, out_conf, out_op_a);
        end
        drive(1'b0, add_conf, '0, '0, '0, 1'b1, 1'b0);
    endtask

`ifdef IEXU_FWD_EN
    task automatic test_fwd();
        in_rs1 = 5'd7;
        in_pend_a = 1'b1;
        drive(1'b1, add_conf, 32'h0, 32'h5, 5'd3, 1'b1, 1'b0);
        in_pend_a = 1'b0;
        in_rs1 = '0;
        checks++;
        if (count !== CW'(1) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_pending count=%0d valid=%b want 1/0", count, out_valid);
        end
        drive(1'b0, add_conf, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_wait valid=%b want 0", out_valid);
        end
        wb_valid = 1'b1; wb_tag = 5'd7; wb_data = 32'h1234;
        drive(1'b0, add_conf, '0, '0, '0, 1'b0, 1'b0);
        wb_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_op_a !== 32'h1234 || out_op_b !== 32'h5) begin
            errors++;
            $display("FAIL fwd_capture valid=%b a=%0h b=%0h want 1/1234/5", out_valid, out_op_a, out_op_b);
        end
        in_rs1 = 5'd9; in_pend_a = 1'b1;
        wb_valid = 1'b1; wb_tag = 5'd9; wb_data = 32'hBEEF;
        drive(1'b1, sub_conf, 32'h0, 32'h1, 5'd4, 1'b1, 1'b0);
        in_rs1 = '0; in_pend_a = 1'b0; wb_valid = 1'b0;
        checks++;
        if (count !== CW'(1) || out_valid !== 1'b1 || out_conf !== sub_conf || out_op_a !== 32'hBEEF) begin
            errors++;
            $display("FAIL fwd_samecycle count=%0d valid=%b conf=%0d a=%0h want 1/1/sub/beef",
                     count, out_valid, out_conf, out_op_a);
        end
        drive(1'b0, add_conf, '0, '0, '0, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_random();
        ment_t    mq [$];
        ment_t    e;
        logic     v, ordy, fl, do_push, do_pop;
        iexu_conf c;
        // Start from a known-empty state on both sides.
        drive(1'b0, add_conf, '0, '0, '0, 1'b0, 1'b1);
        for (int n = 0; n < 300; n++) begin
            checks++;
            if (count !== CW'(mq.size()) || in_ready !== (mq.size() < DEPTH) ||
                out_valid !== (mq.size() != 0)) begin
                errors++;
                $display("FAIL rand_state cyc=%0d count=%0d in_ready=%b valid=%b want %0d/%b/%b",
                         n, count, in_ready, out_valid, mq.size(), mq.size() < DEPTH, mq.size() != 0);
            end
            if (mq.size() != 0) begin
                checks++;
                if (out_conf !== mq[0].conf || out_op_a !== mq[0].a ||
                    out_op_b !== mq[0].b || out_rd !== mq[0].rd) begin
                    errors++;
                    $display("FAIL rand_head cyc=%0d conf=%0d a=%0h b=%0h rd=%0d want %0d/%0h/%0h/%0d",
                             n, out_conf, out_op_a, out_op_b, out_rd,
                             mq[0].conf, mq[0].a, mq[0].b, mq[0].rd);
                end
            end
            v    = ($urandom_range(3) != 0);
            ordy = $urandom_range(1) == 1;
            fl   = ($urandom_range(15) == 0);
            c    = iexu_conf'($urandom_range(7));
            e.conf = c;
            e.a    = $urandom;
            e.b    = $urandom;
            e.rd   = TAGW'($urandom_range(31));
            do_pop  = (mq.size() != 0) && ordy;
            do_push = v && (mq.size() < DEPTH);
            drive(v, c, e.a, e.b, e.rd, ordy, fl);
            if (fl) begin
                mq.delete();
            end else begin
                if (do_pop)  void'(mq.pop_front());
                if (do_push) mq.push_back(e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_conf = add_conf; in_op_a = '0; in_op_b = '0; in_rd = '0;
        test_reset();
        test_fill();
        test_drain_wrap();
        test_back_to_back();
        test_flush();
`ifdef IEXU_FWD_EN
        test_fwd();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
